// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction fetch stage and the branch-resolution block.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JAL    = 2'b10,
        PC_JALR   = 2'b11
    } pc_src_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10,
        DROP = 2'b11
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: redirect-target mux (JALR clears bit 0) and the PC+4 adder.
module fetch_next_pc
    import fetch_stage_pkg::*;
(
    input  pc_src_t     pc_src,
    input  logic [31:0] pc,
    input  logic [31:0] pc_target,
    input  logic [31:0] alu_result,
    output logic        redirect,
    output logic [31:0] target,
    output logic [31:0] pc_plus4
);

    assign redirect = (pc_src != PC_PLUS4);
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        case (pc_src)
            PC_BRANCH, PC_JAL: target = pc_target;
            PC_JALR:           target = {alu_result[31:1], 1'b0};
            default:           target = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, request/ack fetch FSM, stall hold buffer
// and the IF/ID pipeline register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] ALUResultE,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    fetch_state_t state, state_next;
    logic [31:0]  pcf;
    logic [31:0]  hold_instr;
    logic [31:0]  hold_pc;
    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic         accept;
    logic         fetch_done;
    logic         load_fetch;
    logic         load_hold;

    fetch_next_pc u_next_pc (
        .pc_src     (pc_src_t'(PCSrcE)),
        .pc         (pcf),
        .pc_target  (PCTargetE),
        .alu_result (ALUResultE),
        .redirect   (redirect),
        .target     (target),
        .pc_plus4   (pc_plus4)
    );

    assign imem_req   = (state == WAIT);
    assign imem_addr  = pcf;
    // Decode can take a word only when it is neither stalled nor being flushed.
    assign accept     = !StallD && !FlushD;
    assign fetch_done = (state == WAIT) && imem_ack;
    assign load_fetch = fetch_done && !redirect && accept;
    assign load_hold  = (state == HOLD) && !redirect && accept;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!redirect && !StallF) state_next = WAIT;
            WAIT: begin
                if (redirect)          state_next = imem_ack ? IDLE : DROP;
                else if (imem_ack) begin
                    if (!accept)       state_next = HOLD;
                    else if (StallF)   state_next = IDLE;
                end
            end
            HOLD: begin
                if (redirect)          state_next = IDLE;
                else if (accept)       state_next = StallF ? IDLE : WAIT;
            end
            // A redirect arriving with the awaited ack must not leave DROP waiting forever.
            DROP: if (imem_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pcf   <= RESET_PC;
        end else begin
            state <= state_next;
            if (redirect)        pcf <= target;
            else if (fetch_done) pcf <= pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (fetch_done && !accept) begin
            hold_instr <= imem_rdata;
            hold_pc    <= pcf;
        end
    end

    // While in HOLD, PCF already sits at the buffered PC + 4.
    always_ff @(posedge clk) begin
        if (reset) begin
            ValidD   <= 1'b0;
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else if (redirect || FlushD) begin
            ValidD <= 1'b0;
            InstrD <= NOP_INSTR;
        end else if (!StallD) begin
            if (load_fetch) begin
                ValidD   <= 1'b1;
                InstrD   <= imem_rdata;
                PCD      <= pcf;
                PCPlus4D <= pc_plus4;
            end else if (load_hold) begin
                ValidD   <= 1'b1;
                InstrD   <= hold_instr;
                PCD      <= hold_pc;
                PCPlus4D <= pcf;
            end else begin
                ValidD <= 1'b0;
                InstrD <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: memory responder, request/IF-ID scoreboards,
// a redirect vector table and hand-written stall/hold/wrap/reset sequences.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] ALUResultE;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .ALUResultE (ALUResultE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ifid_t;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] tgt;
        logic [31:0] alu;
        bit          ack_same;
        logic [31:0] exp_addr;
    } redir_t;

    logic [31:0] addr_q[$];
    ifid_t       ifid_q[$];
    redir_t      tbl[6];

    int checks = 0;
    int errors = 0;

    bit          auto_mem = 0;
    int          lat_cnt  = 0;
    bit          prev_req = 0;
    logic [31:0] prev_addr = '0;
    bit          prev_valid = 0;
    logic [31:0] prev_pcd = '0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_ifid(input logic [31:0] pc);
        ifid_t e;
        e.instr = mem(pc);
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        ifid_q.push_back(e);
    endtask

    // One clock: monitors sample at the falling edge, then the responder drives the next ack.
    task automatic tick();
        ifid_t e;
        @(posedge clk);
        @(negedge clk);
        if (imem_req && (!prev_req || imem_addr != prev_addr)) begin
            if (addr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL req_unexpected actual=%h required=none", imem_addr);
            end else begin
                chk("req_addr", imem_addr, addr_q.pop_front());
            end
        end
        prev_req  = imem_req;
        prev_addr = imem_addr;
        if (ValidD && (!prev_valid || PCD != prev_pcd)) begin
            if (ifid_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ifid_unexpected actual=%h/%h/%h required=none", InstrD, PCD, PCPlus4D);
            end else begin
                e = ifid_q.pop_front();
                chk("ifid_instr", InstrD, e.instr);
                chk("ifid_pc", PCD, e.pc);
                chk("ifid_pc4", PCPlus4D, e.pc4);
            end
        end
        prev_valid = ValidD;
        prev_pcd   = PCD;
        if (auto_mem) begin
            if (imem_req) begin
                if (lat_cnt == 1) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem(imem_addr);
                    lat_cnt    = 0;
                end else begin
                    imem_ack = 1'b0;
                    lat_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                lat_cnt  = 0;
            end
        end
    endtask

    task automatic wait_addr(input logic [31:0] a);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = imem_req && (imem_addr == a);
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL wait_addr actual=%h required=%h", imem_addr, a);
        end
    endtask

    task automatic wait_pcd(input logic [31:0] a);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = ValidD && (PCD == a);
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL wait_pcd actual=%h required=%h", PCD, a);
        end
    endtask

    task automatic wait_req();
        bit seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            seen = imem_req;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL wait_req actual=0 required=1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'b01, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100};
        tbl[1] = '{2'b11, 32'h0000_0888, 32'h0000_0205, 1'b1, 32'h0000_0204};
        tbl[2] = '{2'b10, 32'h0000_0800, 32'h0000_0999, 1'b1, 32'h0000_0800};
        tbl[3] = '{2'b11, 32'h0000_0444, 32'h0000_0301, 1'b0, 32'h0000_0300};
        tbl[4] = '{2'b10, 32'h0000_0A00, 32'h0000_0003, 1'b0, 32'h0000_0A00};
        tbl[5] = '{2'b01, 32'hFFFF_FFFC, 32'h0000_0001, 1'b0, 32'hFFFF_FFFC};

        reset = 1'b1; PCSrcE = 2'b00; PCTargetE = '0; ALUResultE = '0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        tick(); tick();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, ValidD}, 32'd0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_pc4", PCPlus4D, 32'h0);

        // Sequential fetch 0,4,8,12 with one wait cycle per request; stall on the word at 0x8.
        foreach (tbl[i]) begin end
        addr_q.push_back(32'h0); addr_q.push_back(32'h4);
        addr_q.push_back(32'h8); addr_q.push_back(32'hC);
        push_ifid(32'h0); push_ifid(32'h4); push_ifid(32'h8); push_ifid(32'hC);
        reset = 1'b0;
        auto_mem = 1;
        wait_addr(32'h8);
        StallD = 1'b1;
        for (int i = 0; i < 6 && imem_req; i++) tick();
        tick(); tick();
        chk("hold_req", {31'b0, imem_req}, 32'd0);
        chk("hold_valid", {31'b0, ValidD}, 32'd1);
        chk("hold_pcd", PCD, 32'h4);
        chk("hold_instr", InstrD, mem(32'h4));
        StallD = 1'b0;
        wait_addr(32'hC);
        chk("hold_release_pcd", PCD, 32'h8);
        StallF = 1'b1;
        wait_pcd(32'hC);
        auto_mem = 0;
        imem_ack = 1'b0;

        // Flush wins over a simultaneous decode stall.
        StallD = 1'b1; FlushD = 1'b1;
        tick();
        chk("flush_valid", {31'b0, ValidD}, 32'd0);
        chk("flush_instr", InstrD, NOP);
        StallD = 1'b0; FlushD = 1'b0;
        tick();
        chk("idle_req", {31'b0, imem_req}, 32'd0);

        // Redirect table, starting from a request outstanding at 0x10.
        addr_q.push_back(32'h10);
        StallF = 1'b0;
        tick();
        for (int r = 0; r < 6; r++) begin
            addr_q.push_back(tbl[r].exp_addr);
            PCSrcE = tbl[r].src; PCTargetE = tbl[r].tgt; ALUResultE = tbl[r].alu;
            imem_ack = tbl[r].ack_same; imem_rdata = mem(imem_addr);
            tick();
            PCSrcE = 2'b00; imem_ack = 1'b0;
            chk("redir_valid", {31'b0, ValidD}, 32'd0);
            if (!tbl[r].ack_same) begin
                chk("drop_req", {31'b0, imem_req}, 32'd0);
                imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000;
                tick();
                imem_ack = 1'b0;
                chk("drop_valid", {31'b0, ValidD}, 32'd0);
            end
            wait_req();
        end

        // PC wrap at the top of the address space.
        push_ifid(32'hFFFF_FFFC);
        addr_q.push_back(32'h0);
        imem_ack = 1'b1; imem_rdata = mem(32'hFFFF_FFFC);
        tick();
        imem_ack = 1'b0;
        chk("wrap_pc4", PCPlus4D, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Word parked in HOLD, then a redirect discards it.
        StallD = 1'b1;
        imem_ack = 1'b1; imem_rdata = mem(32'h0);
        tick();
        imem_ack = 1'b0;
        chk("hold2_req", {31'b0, imem_req}, 32'd0);
        PCSrcE = 2'b10; PCTargetE = 32'h40;
        addr_q.push_back(32'h40);
        tick();
        PCSrcE = 2'b00; StallD = 1'b0;
        chk("hold2_valid", {31'b0, ValidD}, 32'd0);
        wait_req();
        chk("hold2_valid_after", {31'b0, ValidD}, 32'd0);

        // Reset while a request is outstanding; the ack right after release is ignored.
        reset = 1'b1;
        tick();
        chk("rst2_req", {31'b0, imem_req}, 32'd0);
        chk("rst2_valid", {31'b0, ValidD}, 32'd0);
        chk("rst2_instr", InstrD, NOP);
        chk("rst2_pcd", PCD, 32'h0);
        chk("rst2_pc4", PCPlus4D, 32'h0);
        addr_q.push_back(32'h0);
        reset = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001;
        tick();
        imem_ack = 1'b0;
        chk("rst2_ack_ignored", {31'b0, ValidD}, 32'd0);
        chk("rst2_first_addr", imem_addr, 32'h0);
        tick();

        chk("sb_addr_empty", addr_q.size(), 32'd0);
        chk("sb_ifid_empty", ifid_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), InstrD value when the IF/ID register is invalid.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 PCSrcE  in  2  redirect select from branch resolution: 00 PC+4, 01 branch taken, 10 JAL, 11 JALR.
REQ-006 PCTargetE  in  32  PC+imm target for branch and JAL.
REQ-007 ALUResultE  in  32  JALR target before LSB clear.
REQ-008 StallF  in  1  inhibits issue of a new instruction-memory request.
REQ-009 StallD  in  1  holds the IF/ID register.
REQ-010 FlushD  in  1  invalidates the IF/ID register.
REQ-011 imem_req  out  1  fetch request, level, held until ack.
REQ-012 imem_addr  out  32  fetch address, equals PCF, stable while imem_req=1.
REQ-013 imem_ack  in  1  one-cycle pulse; imem_rdata is valid that cycle.
REQ-014 imem_rdata  in  32  fetched instruction.
REQ-015 InstrD, PCD, PCPlus4D  out  32 each  IF/ID register contents.
REQ-016 ValidD  out  1  IF/ID register holds a live instruction.

Function
REQ-017 Redirect: PCSrcE!=00. Target is PCTargetE for 01 and 10, and {ALUResultE[31:1],1'b0} for 11.
REQ-018 FSM states: IDLE (nothing outstanding), WAIT (request outstanding), HOLD (fetched word buffered while StallD=1), DROP (outstanding response to be discarded).
REQ-019 IDLE: if StallF=0 and no redirect, go to WAIT with imem_req=1 and imem_addr=PCF.
REQ-020 WAIT with ack, StallD=0, no redirect: IF/ID gets {imem_rdata, PCF, PCF+4} and ValidD=1, PCF<=PCF+4. Next state is WAIT if StallF=0, which gives back-to-back fetch at 1 instruction per cycle under single-cycle ack; otherwise IDLE.
REQ-021 WAIT with ack and StallD=1: latch the word and its PC into the hold buffer, PCF<=PCF+4, go to HOLD with imem_req=0.
REQ-022 HOLD: when StallD falls, move the buffer into IF/ID with ValidD=1, then go to WAIT if StallF=0, else IDLE.
REQ-023 Redirect priority: a redirect overrides stall, ack and the hold buffer. PCF<=target on that edge.
REQ-024 Redirect in IDLE or HOLD: discard the buffer and go to IDLE; the new request issues the following cycle.
REQ-025 Redirect in WAIT without ack: go to DROP with imem_req=0. The next ack is discarded, then go to IDLE.
REQ-026 Redirect in WAIT with ack in the same cycle: discard the data and go to IDLE.
REQ-027 Redirect in DROP: update PCF and stay in DROP.
REQ-028 Redirect or FlushD sets ValidD=0 and InstrD=NOP_INSTR on the next edge. Flush overrides StallD.
REQ-029 StallD=1 with no flush or redirect holds InstrD, PCD, PCPlus4D and ValidD unchanged.
REQ-030 PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-031 An ack outside WAIT or DROP is ignored.

Reset
REQ-032 On reset: PCF=RESET_PC, state=IDLE, imem_req=0, ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, hold buffer invalid.
REQ-033 Reset mid-WAIT abandons the request. Any ack in the first cycle after reset is ignored.
REQ-034 Reset has priority over redirect, stall and ack.

Structure
REQ-035 The shared package holds: the PCSrc enum (PC_PLUS4, PC_BRANCH, PC_JAL, PC_JALR), the fetch FSM state enum, and the NOP_INSTR constant; the branch-resolution block uses the same PCSrc enum.
REQ-036 One sub-module, fetch_next_pc, holds the combinational redirect-target mux with JALR LSB clear and the PC+4 adder. The FSM, PC register, hold buffer and IF/ID register stay in fetch_stage.

Verification
REQ-037 Reset release with ack returned 1 cycle after each request: imem_addr sequence is 0,4,8,12, and ValidD rises with InstrD matching imem_rdata and PCD=0.
REQ-038 StallD=1 while ack returns the word for PC=0x8: HOLD is entered and IF/ID is unchanged. StallD falls: InstrD=word, PCD=0x8, and the next request goes to 0xC.
REQ-039 PCSrcE=01 with PCTargetE=0x100 during WAIT on 0x10, ack one cycle later: the 0x10 data is discarded, ValidD=0, and the next request goes to 0x100.
REQ-040 PCSrcE=11 with ALUResultE=0x205 in the same cycle as an ack: the data is dropped and the next imem_addr=0x204.
REQ-041 PCF=0xFFFF_FFFC with an ack: PCPlus4D=0 and the next imem_addr=0.
REQ-042 Reset asserted while WAIT is outstanding and an ack arrives the next cycle: outputs match REQ-032 and the first request after release is RESET_PC.
